ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 129 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (33-cycle shift-add / restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       MulDivOp,
  input  logic             Start,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV  = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI  = 3'b101, OP_MTLO = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  state_t r_state, w_next;

  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_dvd, r_hi, r_lo;
  logic             r_is_div, r_neg_q, r_neg_r, r_dz, r_done;

  logic w_idle_go, w_go_md, w_go_mt, w_signed, w_is_mul_op;
  assign w_idle_go   = (r_state == S_IDLE) && Start && !Flush;
  assign w_is_mul_op = (MulDivOp == OP_MULT) || (MulDivOp == OP_MULTU);
  assign w_go_md     = w_idle_go && (w_is_mul_op || MulDivOp == OP_DIV || MulDivOp == OP_DIVU);
  assign w_go_mt     = w_idle_go && (MulDivOp == OP_MTHI || MulDivOp == OP_MTLO);
  assign w_signed    = (MulDivOp == OP_MULT) || (MulDivOp == OP_DIV);

  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_abs_a = (w_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign w_abs_b = (w_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // Multiply step: {acc,b} holds partial product high half and remaining multiplier bits.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_b[WIDTH-1:1]};

  // Restoring divide step: dividend bits shift out of b into the remainder, quotient bits in.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_qbit;
  assign w_rem_sh = {r_acc, r_b[WIDTH-1]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_a};
  assign w_qbit   = !w_diff[WIDTH+1];

  logic [2*WIDTH-1:0] w_prod_mag, w_prod, w_res;
  logic [WIDTH-1:0]   w_quo, w_rem;
`ifdef MULDIV_FAST_MUL_EN
  assign w_prod_mag = (2*WIDTH)'(r_a) * (2*WIDTH)'(r_b);
`else
  assign w_prod_mag = {r_acc, r_b};
`endif
  assign w_prod = r_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quo  = r_neg_q ? -r_b : r_b;
  assign w_rem  = r_neg_r ? -r_acc : r_acc;
  // Divide-by-zero bypasses sign correction so both DIV and DIVU return the raw dividend.
  assign w_res  = !r_is_div ? w_prod : (r_dz ? {r_dvd, {WIDTH{1'b1}}} : {w_rem, w_quo});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go_md) begin
`ifdef MULDIV_FAST_MUL_EN
        w_next = w_is_mul_op ? S_FIX : S_CALC;
`else
        w_next = S_CALC;
`endif
      end
      S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (Flush) w_next = S_IDLE;
  end

  always_comb begin
    Busy = (r_state != S_IDLE);
    Done = r_done;
    HI   = r_hi;
    LO   = r_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_a <= '0; r_b <= '0; r_acc <= '0; r_dvd <= '0;
      r_hi <= '0; r_lo <= '0; r_is_div <= 1'b0; r_neg_q <= 1'b0;
      r_neg_r <= 1'b0; r_dz <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX) && !Flush;
      if (w_go_md) begin
        r_a      <= w_abs_b;
        r_b      <= w_abs_a;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_dvd    <= SrcA;
        r_is_div <= !w_is_mul_op;
        r_neg_q  <= w_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
        r_neg_r  <= w_signed && SrcA[WIDTH-1];
        r_dz     <= (SrcB == '0);
      end else if (r_state == S_CALC && !Flush) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_is_div) begin
          r_acc <= w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_b   <= {r_b[WIDTH-2:0], w_qbit};
        end else begin
          {r_acc, r_b} <= w_mul_next;
        end
      end else if (r_state == S_FIX && !Flush) begin
        {r_hi, r_lo} <= w_res;
      end
      if (w_go_mt) begin
        if (MulDivOp == OP_MTHI) r_hi <= SrcA;
        else                     r_lo <= SrcA;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed table-driven bench for ex_muldiv_unit plus flush/reset/busy-start sequences.
// Honors MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_ex_muldiv_unit;
  localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV  = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI  = 3'b101, OP_MTLO = 3'b110;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [2:0]  MulDivOp = '0;
  logic        Start = 1'b0, Flush = 1'b0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int ntests = 0, nfail = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .MulDivOp(MulDivOp),
    .Start(Start), .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    string       nm;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic int exp_busy(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (op == OP_MULT || op == OP_MULTU) return 1;
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input string nm);
    int n;
    @(negedge clk); Start = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
    @(negedge clk); Start = 1'b0; MulDivOp = 3'b000; SrcA = ~a; SrcB = b + 32'd1;
    n = 0;
    while (Busy && n < 100) begin n++; @(negedge clk); end
    chk({nm, " busy_cycles"}, 64'(n), 64'(exp_busy(op)));
    chk({nm, " done"}, 64'(Done), 64'd1);
    chk({nm, " hi"}, 64'(HI), 64'(hi));
    chk({nm, " lo"}, 64'(LO), 64'(lo));
    @(negedge clk);
    chk({nm, " done_1cyc"}, 64'(Done), 64'd0);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    @(negedge clk); Start = 1'b1; MulDivOp = op; SrcA = v;
    @(negedge clk); Start = 1'b0; MulDivOp = 3'b000;
  endtask

  initial begin
    int n, dseen;
    vt[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_m2x3"};
    vt[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vt[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"};
    vt[3]  = '{OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, "multu_shift"};
    vt[4]  = '{OP_MULT,  32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, "mult_7xm5"};
    vt[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7by2"};
    vt[6]  = '{OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, "divu_by0"};
    vt[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0"};
    vt[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vt[9]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, "divu_100by7"};
    vt[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7bym2"};
    vt[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, "divu_max"};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst done", 64'(Done), 64'd0);
    chk("rst hilo", {HI, LO}, 64'd0);
    rst = 1'b0;

    // MTLO / MTHI
    @(negedge clk); Start = 1'b1; MulDivOp = OP_MTLO; SrcA = 32'h12345678;
    @(negedge clk); Start = 1'b0; MulDivOp = 3'b000;
    chk("mtlo lo", 64'(LO), 64'h12345678);
    chk("mtlo busy", 64'(Busy), 64'd0);
    chk("mtlo done", 64'(Done), 64'd0);
    mt(OP_MTHI, 32'hAAAA5555);
    chk("mthi hi", 64'(HI), 64'hAAAA5555);

    foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].nm);

    // Start while busy is ignored
    @(negedge clk); Start = 1'b1; MulDivOp = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk); Start = 1'b0; MulDivOp = 3'b000;
    n = 0;
    while (Busy && n < 100) begin
      if (n == 4) begin Start = 1'b1; MulDivOp = OP_MTLO; SrcA = 32'hDEADBEEF; end
      if (n == 5) begin MulDivOp = OP_MULT; SrcB = 32'd3; end
      if (n == 6) begin Start = 1'b0; MulDivOp = 3'b000; end
      n++; @(negedge clk);
    end
    chk("busystart busy_cycles", 64'(n), 64'd33);
    chk("busystart hilo", {HI, LO}, {32'd2, 32'd14});

    // Flush mid-divide
    mt(OP_MTLO, 32'h12345678);
    mt(OP_MTHI, 32'hAAAA5555);
    @(negedge clk); Start = 1'b1; MulDivOp = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk); Start = 1'b0; MulDivOp = 3'b000;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk); Flush = 1'b0;
    chk("flush busy", 64'(Busy), 64'd0);
    dseen = 0;
    repeat (40) begin
      if (Done) dseen++;
      @(negedge clk);
    end
    chk("flush no_done", 64'(dseen), 64'd0);
    chk("flush hilo", {HI, LO}, {32'hAAAA5555, 32'h12345678});

    // Flush beats simultaneous Start
    @(negedge clk); Start = 1'b1; Flush = 1'b1; MulDivOp = OP_MTLO; SrcA = 32'hFFFF0000;
    @(negedge clk); Start = 1'b0; Flush = 1'b0; MulDivOp = 3'b000;
    chk("flushstart lo", 64'(LO), 64'h12345678);
    chk("flushstart busy", 64'(Busy), 64'd0);

    // Asynchronous reset mid-multiply
    @(negedge clk); Start = 1'b1; MulDivOp = OP_MULT; SrcA = 32'd5; SrcB = 32'd6;
    @(negedge clk); Start = 1'b0; MulDivOp = 3'b000;
`ifdef MULDIV_FAST_MUL_EN
    #1;
    rst = 1'b1; #1;
`else
    repeat (14) @(negedge clk);
    chk("midrst pre busy", 64'(Busy), 64'd1);
    rst = 1'b1; #1;
`endif
    chk("midrst busy", 64'(Busy), 64'd0);
    chk("midrst hilo", {HI, LO}, 64'd0);
    chk("midrst done", 64'(Done), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(OP_MULT, 32'd5, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, "postrst_mult");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
